// File: rtl/xing_pkg.sv
// Shared encodings for the pedestrian crossing controller: FSM state codes
// and the one-hot light patterns driven onto the traffic/pedestrian heads.
package xing_pkg;

  typedef enum logic [2:0] {
    S_INIT_RED  = 3'd0,
    S_GREEN     = 3'd1,
    S_YELLOW    = 3'd2,
    S_ALL_RED   = 3'd3,
    S_WALK      = 3'd4,
    S_PED_CLEAR = 3'd5,
    S_NIGHT     = 3'd6
  } xing_state_e;

  // Traffic head, {green,yellow,red}
  localparam logic [2:0] TL_RED    = 3'b001;
  localparam logic [2:0] TL_YELLOW = 3'b010;
  localparam logic [2:0] TL_GREEN  = 3'b100;
  localparam logic [2:0] TL_DARK   = 3'b000;

  // Pedestrian head, {walk,dont_walk}
  localparam logic [1:0] PL_DONT_WALK = 2'b01;
  localparam logic [1:0] PL_WALK      = 2'b10;
  localparam logic [1:0] PL_DARK      = 2'b00;

endpackage

// File: rtl/xing_light_ctrl_btn_sync_edge.sv
// Pedestrian button front end: each button bit is brought into the clk_out
// domain through two flops, then a third flop gives the rising-edge detect.
// Any synchronised rising edge raises btn_rise for one cycle.
module btn_sync_edge #(
  parameter int N_BTN = 2
) (
  input  logic             clk_out,
  input  logic             reset,
  input  logic [N_BTN-1:0] btn,
  output logic             btn_rise
);

  logic [N_BTN-1:0] sync1, sync2, sync_prev;

  // Two-flop synchroniser plus history flop for edge detection
  always_ff @(posedge clk_out or posedge reset) begin
    if (reset) begin
      sync1     <= '0;
      sync2     <= '0;
      sync_prev <= '0;
    end else begin
      sync1     <= btn;
      sync2     <= sync1;
      sync_prev <= sync2;
    end
  end

  assign btn_rise = |(sync2 & ~sync_prev);

endmodule

// File: rtl/xing_light_ctrl.sv
// Pedestrian crossing controller. Phase timing counts tick strobes only;
// the light outputs are registered from the next-state decode so they
// change on the same edge as the state register.
module xing_light_ctrl
  import xing_pkg::*;
#(
  parameter int N_BTN     = 2,
  parameter int CNT_W     = 8,
  parameter int GREEN_MIN = 30,
  parameter int YELLOW_T  = 3,
  parameter int ALLRED_T  = 2,
  parameter int WALK_T    = 10,
  parameter int CLEAR_T   = 5
) (
  input  logic             clk_out,
  input  logic             reset,
  input  logic             tick,
  input  logic [N_BTN-1:0] btn,
  input  logic             night,
  output logic [2:0]       traff_state,
  output logic [1:0]       pedes_state,
  output logic             req_pending,
  output logic [2:0]       phase
);

  // Counter value on the expiring tick of each phase
  localparam logic [CNT_W-1:0] GREEN_LAST  = CNT_W'(GREEN_MIN - 1);
  localparam logic [CNT_W-1:0] YELLOW_LAST = CNT_W'(YELLOW_T - 1);
  localparam logic [CNT_W-1:0] ALLRED_LAST = CNT_W'(ALLRED_T - 1);
  localparam logic [CNT_W-1:0] WALK_LAST   = CNT_W'(WALK_T - 1);
  localparam logic [CNT_W-1:0] CLEAR_LAST  = CNT_W'(CLEAR_T - 1);

  xing_state_e      state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic             blink, blink_nx;
  logic             req_nx;
  logic [2:0]       traff_nx;
  logic [1:0]       pedes_nx;
  logic             btn_rise;
  logic             night_s1, night_s;
  logic             entering;

  btn_sync_edge #(.N_BTN(N_BTN)) u_btn (
    .clk_out  (clk_out),
    .reset    (reset),
    .btn      (btn),
    .btn_rise (btn_rise)
  );

  // Night request is a level; synchronise it like the buttons
  always_ff @(posedge clk_out or posedge reset) begin
    if (reset) begin
      night_s1 <= 1'b0;
      night_s  <= 1'b0;
    end else begin
      night_s1 <= night;
      night_s  <= night_s1;
    end
  end

  // Next-state, phase counter, blink phase, request latch and light decode
  always_comb begin
    state_nx = state;
    case (state)
      S_INIT_RED:  if (night_s) state_nx = S_NIGHT;
                   else if (tick && cnt == ALLRED_LAST) state_nx = S_GREEN;
      // Night beats a pending crossing when both are ready
      S_GREEN:     if (night_s) state_nx = S_NIGHT;
                   else if (tick && cnt == GREEN_LAST && (req_pending || btn_rise))
                     state_nx = S_YELLOW;
      S_YELLOW:    if (tick && cnt == YELLOW_LAST) state_nx = S_ALL_RED;
      S_ALL_RED:   if (tick && cnt == ALLRED_LAST) state_nx = S_WALK;
      S_WALK:      if (tick && cnt == WALK_LAST)   state_nx = S_PED_CLEAR;
      S_PED_CLEAR: if (tick && cnt == CLEAR_LAST)  state_nx = S_INIT_RED;
      S_NIGHT:     if (!night_s) state_nx = S_INIT_RED;
      default:     state_nx = S_INIT_RED;
    endcase

    entering = (state_nx != state);

    // Counter restarts on every entry; GREEN holds at its minimum so a late
    // request is served on the very next tick
    cnt_nx = cnt;
    if (entering)
      cnt_nx = '0;
    else if (tick && !(state == S_GREEN && cnt == GREEN_LAST))
      cnt_nx = cnt + 1'b1;

    blink_nx = blink;
    if (entering)  blink_nx = 1'b0;
    else if (tick) blink_nx = ~blink;

    // Request is served by WALK, so clear on entry and ignore presses
    // during it; NIGHT keeps it clear as well
    req_nx = req_pending;
    if (state_nx == S_WALK || state_nx == S_NIGHT || state == S_WALK)
      req_nx = 1'b0;
    else if (btn_rise)
      req_nx = 1'b1;

    traff_nx = TL_RED;
    pedes_nx = PL_DONT_WALK;
    case (state_nx)
      S_GREEN:     traff_nx = TL_GREEN;
      S_YELLOW:    traff_nx = TL_YELLOW;
      S_WALK:      pedes_nx = PL_WALK;
      S_PED_CLEAR: pedes_nx = blink_nx ? PL_DARK : PL_DONT_WALK;
      S_NIGHT: begin
        traff_nx = blink_nx ? TL_DARK : TL_YELLOW;
        pedes_nx = PL_DARK;
      end
      default: ;
    endcase
  end

  // State, timing and registered outputs
  always_ff @(posedge clk_out or posedge reset) begin
    if (reset) begin
      state       <= S_INIT_RED;
      cnt         <= '0;
      blink       <= 1'b0;
      req_pending <= 1'b0;
      traff_state <= TL_RED;
      pedes_state <= PL_DONT_WALK;
    end else begin
      state       <= state_nx;
      cnt         <= cnt_nx;
      blink       <= blink_nx;
      req_pending <= req_nx;
      traff_state <= traff_nx;
      pedes_state <= pedes_nx;
    end
  end

  assign phase = state;

endmodule

// File: tb/tb_xing_light_ctrl.sv
// Directed bench for xing_light_ctrl with tick held high every cycle and
// short phase timings. Expected sequences are written out per cycle.
module tb_xing_light_ctrl;
  import xing_pkg::*;

  logic       clk_out = 1'b0;
  logic       reset;
  logic       tick;
  logic [1:0] btn;
  logic       night;
  logic [2:0] traff_state;
  logic [1:0] pedes_state;
  logic       req_pending;
  logic [2:0] phase;

  int checks = 0;
  int errors = 0;

  xing_light_ctrl #(
    .N_BTN(2), .CNT_W(8), .GREEN_MIN(4), .YELLOW_T(2),
    .ALLRED_T(1), .WALK_T(3), .CLEAR_T(2)
  ) dut (
    .clk_out     (clk_out),
    .reset       (reset),
    .tick        (tick),
    .btn         (btn),
    .night       (night),
    .traff_state (traff_state),
    .pedes_state (pedes_state),
    .req_pending (req_pending),
    .phase       (phase)
  );

  always #5 clk_out = ~clk_out;

  task automatic step();
    @(posedge clk_out);
    #1;
  endtask

  // Reset held across clock edges, then released just after an edge
  task automatic do_reset();
    btn = 2'b00; night = 1'b0; tick = 1'b1;
    step();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    btn = 2'b00; night = 1'b0; tick = 1'b1;
    reset = 1'b1;
    #2;
    step();
    step();
    checks++;
    if ({phase, traff_state, pedes_state, req_pending} !== {3'd0, 3'b001, 2'b01, 1'b0}) begin
      errors++;
      $display("FAIL reset_values got ph=%0d tr=%b pd=%b rq=%b exp ph=0 tr=001 pd=01 rq=0",
               phase, traff_state, pedes_state, req_pending);
    end
    reset = 1'b0;
  endtask

  task automatic test_idle();
    do_reset();
    for (int i = 0; i < 10; i++) begin
      step();
      checks++;
      if ({phase, traff_state, pedes_state, req_pending} !== {3'd1, 3'b100, 2'b01, 1'b0}) begin
        errors++;
        $display("FAIL idle_green step %0d got ph=%0d tr=%b pd=%b rq=%b exp ph=1 tr=100 pd=01 rq=0",
                 i + 1, phase, traff_state, pedes_state, req_pending);
      end
    end
  endtask

  task automatic test_ped();
    int         ph[14] = '{1,1,1,1,2,2,3,4,4,4,5,5,0,1};
    logic [2:0] tr[14] = '{3'b100,3'b100,3'b100,3'b100,3'b010,3'b010,3'b001,
                           3'b001,3'b001,3'b001,3'b001,3'b001,3'b001,3'b100};
    logic [1:0] pd[14] = '{2'b01,2'b01,2'b01,2'b01,2'b01,2'b01,2'b01,
                           2'b10,2'b10,2'b10,2'b01,2'b00,2'b01,2'b01};
    logic       rq[14] = '{0,0,0,0,1,1,1,0,0,0,0,0,0,0};
    do_reset();
    for (int i = 0; i < 14; i++) begin
      step();
      checks++;
      if (phase !== 3'(ph[i]) || traff_state !== tr[i] || pedes_state !== pd[i] ||
          req_pending !== rq[i]) begin
        errors++;
        $display("FAIL ped_cycle step %0d got ph=%0d tr=%b pd=%b rq=%b exp ph=%0d tr=%b pd=%b rq=%b",
                 i + 1, phase, traff_state, pedes_state, req_pending, ph[i], tr[i], pd[i], rq[i]);
      end
      btn = (i == 1) ? 2'b10 : 2'b00;
    end
  endtask

  task automatic test_walk_btn();
    int   ph[18] = '{1,1,1,1,2,2,3,4,4,4,5,5,0,1,1,1,1,2};
    logic rq[18] = '{0,0,0,0,1,1,1,0,0,0,0,0,0,1,1,1,1,1};
    do_reset();
    for (int i = 0; i < 18; i++) begin
      step();
      checks++;
      if (phase !== 3'(ph[i]) || req_pending !== rq[i]) begin
        errors++;
        $display("FAIL walk_clear_btn step %0d got ph=%0d rq=%b exp ph=%0d rq=%b",
                 i + 1, phase, req_pending, ph[i], rq[i]);
      end
      btn = (i == 1) ? 2'b10 : (i == 7 || i == 10) ? 2'b01 : 2'b00;
    end
  endtask

  task automatic test_night();
    int         ph[20] = '{1,1,1,1,2,2,3,4,4,4,5,5,0,6,6,6,6,6,6,0};
    logic [2:0] tr[20] = '{3'b100,3'b100,3'b100,3'b100,3'b010,3'b010,3'b001,
                           3'b001,3'b001,3'b001,3'b001,3'b001,3'b001,
                           3'b010,3'b000,3'b010,3'b000,3'b010,3'b000,3'b001};
    logic [1:0] pd[20] = '{2'b01,2'b01,2'b01,2'b01,2'b01,2'b01,2'b01,
                           2'b10,2'b10,2'b10,2'b01,2'b00,2'b01,
                           2'b00,2'b00,2'b00,2'b00,2'b00,2'b00,2'b01};
    do_reset();
    for (int i = 0; i < 20; i++) begin
      step();
      checks++;
      if (phase !== 3'(ph[i]) || traff_state !== tr[i] || pedes_state !== pd[i] ||
          req_pending !== 1'b0 && i >= 13) begin
        errors++;
        $display("FAIL night_mode step %0d got ph=%0d tr=%b pd=%b rq=%b exp ph=%0d tr=%b pd=%b",
                 i + 1, phase, traff_state, pedes_state, req_pending, ph[i], tr[i], pd[i]);
      end
      btn = (i == 1) ? 2'b10 : 2'b00;
      if (i == 4)  night = 1'b1;
      if (i == 16) night = 1'b0;
    end
  endtask

  task automatic test_reset_mid();
    // Abort during WALK
    do_reset();
    for (int i = 0; i < 9; i++) begin
      step();
      btn = (i == 1) ? 2'b10 : 2'b00;
    end
    checks++;
    if (phase !== 3'd4) begin
      errors++;
      $display("FAIL reset_mid_in_walk got ph=%0d exp ph=4", phase);
    end
    reset = 1'b1;
    #2;
    checks++;
    if ({phase, traff_state, pedes_state, req_pending} !== {3'd0, 3'b001, 2'b01, 1'b0}) begin
      errors++;
      $display("FAIL reset_mid_walk got ph=%0d tr=%b pd=%b rq=%b exp ph=0 tr=001 pd=01 rq=0",
               phase, traff_state, pedes_state, req_pending);
    end
    reset = 1'b0;
    // Abort in YELLOW with a request latched; it must not survive
    do_reset();
    for (int i = 0; i < 6; i++) begin
      step();
      btn = (i == 1) ? 2'b10 : 2'b00;
    end
    checks++;
    if (req_pending !== 1'b1 || phase !== 3'd2) begin
      errors++;
      $display("FAIL reset_mid_pre got ph=%0d rq=%b exp ph=2 rq=1", phase, req_pending);
    end
    reset = 1'b1;
    #2;
    checks++;
    if ({phase, traff_state, pedes_state, req_pending} !== {3'd0, 3'b001, 2'b01, 1'b0}) begin
      errors++;
      $display("FAIL reset_mid_yellow got ph=%0d tr=%b pd=%b rq=%b exp ph=0 tr=001 pd=01 rq=0",
               phase, traff_state, pedes_state, req_pending);
    end
    reset = 1'b0;
    // Back to normal after release
    step();
    checks++;
    if (phase !== 3'd1 || req_pending !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_after got ph=%0d rq=%b exp ph=1 rq=0", phase, req_pending);
    end
  endtask

  initial begin
    reset = 1'b1;
    test_reset();
    test_idle();
    test_ped();
    test_walk_btn();
    test_night();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
